// File: rtl/acc_loop_pkg.sv
// Shared types and helpers for the multi-flit loopback tile: FSM state encodings,
// payload transform modes, header rewrite and payload transform functions.
package acc_loop_pkg;

    localparam int BW_P      = 32;
    localparam int XY_SZ_P   = 3;
    localparam int SRC_LSB_P = 18;
    localparam int ID_W_P    = 2 * XY_SZ_P;

    typedef enum logic [1:0] {
        IN_HDR  = 2'd0,
        IN_PLD  = 2'd1,
        IN_DROP = 2'd2,
        IN_WAIT = 2'd3
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_HDR  = 2'd1,
        OUT_PLD  = 2'd2
    } out_state_t;

    typedef enum logic [1:0] {
        MODE_LOOP  = 2'd0,
        MODE_INC   = 2'd1,
        MODE_INV   = 2'd2,
        MODE_LOOP3 = 2'd3
    } mode_t;

    // Reply goes back to the sender: old source becomes destination, our id becomes source.
    function automatic logic [BW_P-1:0] hdr_swap(input logic [BW_P-1:0] hdr,
                                                 input logic [ID_W_P-1:0] id);
        logic [BW_P-1:0] res;
        res = hdr;
        res[SRC_LSB_P +: ID_W_P] = id;
        res[ID_W_P-1:0]          = hdr[SRC_LSB_P +: ID_W_P];
        return res;
    endfunction

    function automatic logic [BW_P-1:0] xform(input logic [BW_P-1:0] data, input mode_t mode);
        logic [BW_P-1:0] res;
        case (mode)
            MODE_INC: res = data + 32'd1;
            MODE_INV: res = ~data;
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/acc_loop_pbuf.sv
// Payload store for one packet: register file with a synchronous write port
// and a combinational read port.
module acc_loop_pbuf #(
    parameter int BW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [BW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [BW-1:0] rd_data
);

    logic [BW-1:0] mem_r [DEPTH];

    // Storage write; contents need no reset since len gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/acc_loop_mf.sv
// Store-and-forward loopback tile: buffers one whole NoC packet, then returns it
// to its source with a rewritten header and a per-packet payload transform.
module acc_loop_mf
    import acc_loop_pkg::*;
#(
    parameter int BW      = BW_P,
    parameter int BWB     = BW / 8,
    parameter int XY_SZ   = XY_SZ_P,
    parameter int SRC_LSB = SRC_LSB_P,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk_line,
    input  logic               clk_line_rst_low,
    input  logic [2*XY_SZ-1:0] HsrcId,
    input  logic [1:0]         cfg_mode,
    input  logic               stream_in_TVALID,
    input  logic [BW-1:0]      stream_in_TDATA,
    input  logic [BWB-1:0]     stream_in_TKEEP,
    input  logic               stream_in_TLAST,
    output logic               stream_in_TREADY,
    input  logic               stream_out_TREADY,
    output logic               stream_out_TVALID,
    output logic [BW-1:0]      stream_out_TDATA,
    output logic [BWB-1:0]     stream_out_TKEEP,
    output logic               stream_out_TLAST,
    output logic [CNT_W-1:0]   pkt_count,
    output logic [CNT_W-1:0]   drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    in_state_t        in_state_r;
    out_state_t       out_state_r;
    mode_t            mode_r;
    logic             in_ready_r;
    logic [PTR_W-1:0] wr_ptr_r, len_r, rd_ptr_r, rd_next_s;
    logic [BW-1:0]    hdr_r, hdr_new_s, rd_data_s, pld_new_s;
    logic             out_valid_r, out_last_r;
    logic [BW-1:0]    out_data_r;
    logic [CNT_W-1:0] pkt_cnt_r, drop_cnt_r;
    logic             in_hs_s, out_hs_s, out_done_s, wr_en_s;
    logic             unused_keep;

    assign unused_keep = ^stream_in_TKEEP;
    assign in_hs_s     = stream_in_TVALID & in_ready_r;
    assign out_hs_s    = out_valid_r & stream_out_TREADY;
    assign out_done_s  = out_hs_s & out_last_r;
    assign wr_en_s     = in_hs_s && (in_state_r == IN_PLD) && (wr_ptr_r != DEPTH_PTR);

    if (BW == BW_P && XY_SZ == XY_SZ_P && SRC_LSB == SRC_LSB_P) begin : g_pkg_fn
        assign hdr_new_s = hdr_swap(hdr_r, HsrcId);
        assign pld_new_s = xform(rd_data_s, mode_r);
    end else begin : g_generic
        // Same rewrite and transform as the package helpers, for non-default geometry.
        always_comb begin
            hdr_new_s = hdr_r;
            hdr_new_s[SRC_LSB +: 2*XY_SZ] = HsrcId;
            hdr_new_s[2*XY_SZ-1:0]        = hdr_r[SRC_LSB +: 2*XY_SZ];
            case (mode_r)
                MODE_INC: pld_new_s = rd_data_s + BW'(1);
                MODE_INV: pld_new_s = ~rd_data_s;
                default:  pld_new_s = rd_data_s;
            endcase
        end
    end

    acc_loop_pbuf #(.BW(BW), .DEPTH(DEPTH), .AW(AW)) u_pbuf (
        .clk     (clk_line),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (stream_in_TDATA),
        .rd_addr (rd_next_s[AW-1:0]),
        .rd_data (rd_data_s)
    );

    // Index of the payload flit to present after the current output handshake.
    always_comb begin
        if (out_state_r == OUT_HDR) begin
            rd_next_s = '0;
        end else begin
            rd_next_s = rd_ptr_r + PTR_W'(1);
        end
    end

    // Input FSM: capture header and payload, drop oversize packets, hold off during output.
    always_ff @(posedge clk_line) begin
        if (!clk_line_rst_low) begin
            in_state_r <= IN_HDR;
            in_ready_r <= 1'b0;
            wr_ptr_r   <= '0;
            len_r      <= '0;
            hdr_r      <= '0;
            mode_r     <= MODE_LOOP;
            drop_cnt_r <= '0;
        end else begin
            case (in_state_r)
                IN_HDR: begin
                    in_ready_r <= 1'b1;
                    if (in_hs_s) begin
                        hdr_r    <= stream_in_TDATA;
                        mode_r   <= mode_t'(cfg_mode);
                        wr_ptr_r <= '0;
                        if (stream_in_TLAST) begin
                            len_r      <= '0;
                            in_state_r <= IN_WAIT;
                            in_ready_r <= 1'b0;
                        end else begin
                            in_state_r <= IN_PLD;
                        end
                    end
                end
                IN_PLD: begin
                    if (in_hs_s) begin
                        if (wr_ptr_r == DEPTH_PTR) begin
                            // Buffer already full: any further flit makes the packet oversize.
                            wr_ptr_r <= '0;
                            if (stream_in_TLAST) begin
                                if (drop_cnt_r != {CNT_W{1'b1}}) begin
                                    drop_cnt_r <= drop_cnt_r + CNT_W'(1);
                                end
                                in_state_r <= IN_HDR;
                            end else begin
                                in_state_r <= IN_DROP;
                            end
                        end else begin
                            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                            if (stream_in_TLAST) begin
                                len_r      <= wr_ptr_r + PTR_W'(1);
                                in_state_r <= IN_WAIT;
                                in_ready_r <= 1'b0;
                            end
                        end
                    end
                end
                IN_DROP: begin
                    if (in_hs_s && stream_in_TLAST) begin
                        if (drop_cnt_r != {CNT_W{1'b1}}) begin
                            drop_cnt_r <= drop_cnt_r + CNT_W'(1);
                        end
                        wr_ptr_r   <= '0;
                        in_state_r <= IN_HDR;
                    end
                end
                IN_WAIT: begin
                    if (out_done_s) begin
                        in_state_r <= IN_HDR;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    in_state_r <= IN_HDR;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Output FSM: replay header then transformed payload with registered flit outputs.
    always_ff @(posedge clk_line) begin
        if (!clk_line_rst_low) begin
            out_state_r <= OUT_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            rd_ptr_r    <= '0;
            pkt_cnt_r   <= '0;
        end else begin
            case (out_state_r)
                OUT_IDLE: begin
                    if (in_state_r == IN_WAIT) begin
                        out_state_r <= OUT_HDR;
                        out_valid_r <= 1'b1;
                        out_data_r  <= hdr_new_s;
                        out_last_r  <= (len_r == '0);
                    end
                end
                OUT_HDR, OUT_PLD: begin
                    if (out_hs_s) begin
                        if (out_last_r) begin
                            out_state_r <= OUT_IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            pkt_cnt_r   <= pkt_cnt_r + CNT_W'(1);
                        end else begin
                            out_state_r <= OUT_PLD;
                            rd_ptr_r    <= rd_next_s;
                            out_data_r  <= pld_new_s;
                            out_last_r  <= ((rd_next_s + PTR_W'(1)) == len_r);
                        end
                    end
                end
                default: begin
                    out_state_r <= OUT_IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end

    assign stream_in_TREADY  = in_ready_r;
    assign stream_out_TVALID = out_valid_r;
    assign stream_out_TDATA  = out_data_r;
    assign stream_out_TLAST  = out_last_r;
    assign stream_out_TKEEP  = {BWB{1'b1}};
    assign pkt_count         = pkt_cnt_r;
    assign drop_count        = drop_cnt_r;

endmodule

// File: tb/tb_acc_loop_mf.sv
// Directed bench for acc_loop_mf: header rewrite, transforms, header-only,
// full-depth and oversize packets, output back-pressure and mid-packet reset.
module tb_acc_loop_mf;

    logic        clk = 1'b0;
    logic        rst_low;
    logic [5:0]  src_id;
    logic [1:0]  mode;
    logic        in_valid, in_last, in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_keep, out_keep;
    logic        out_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [15:0] pkt_cnt, drop_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    acc_loop_mf dut (
        .clk_line          (clk),
        .clk_line_rst_low  (rst_low),
        .HsrcId            (src_id),
        .cfg_mode          (mode),
        .stream_in_TVALID  (in_valid),
        .stream_in_TDATA   (in_data),
        .stream_in_TKEEP   (in_keep),
        .stream_in_TLAST   (in_last),
        .stream_in_TREADY  (in_ready),
        .stream_out_TREADY (out_ready),
        .stream_out_TVALID (out_valid),
        .stream_out_TDATA  (out_data),
        .stream_out_TKEEP  (out_keep),
        .stream_out_TLAST  (out_last),
        .pkt_count         (pkt_cnt),
        .drop_count        (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Collects n flits with the given ready duty (percent) and compares against exp_q.
    task automatic recv(input string tag, input int duty, input int n);
        int          got = 0;
        int          t   = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_d = 32'd0;
        logic [31:0] e;
        while (got < n && t < 3000) begin
            @(negedge clk);
            t++;
            out_ready = ($urandom_range(99) < duty);
            if (out_valid) begin
                if (prev_stall) check({tag, "_stable"}, out_data, prev_d);
                if (out_ready) begin
                    e = exp_q.pop_front();
                    check({tag, "_data"}, out_data, e);
                    check({tag, "_last"}, {31'd0, out_last}, {31'd0, (got == n - 1)});
                    got++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
        end
        check({tag, "_count"}, got, n);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_low   = 1'b0;
        src_id    = 6'b010_001;
        mode      = 2'd0;
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_last   = 1'b0;
        in_keep   = 4'hF;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_low   = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("keep_ones", {28'd0, out_keep}, 32'h0000000F);

        // Single packet, loopback; TVALID one cycle after the last input handshake
        send(32'hAB740011, 1'b0);
        send(32'h12345678, 1'b1);
        @(negedge clk);
        check("t1_valid_lat0", {31'd0, out_valid}, 32'd0);
        check("t1_in_blocked", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("t1_valid_lat1", {31'd0, out_valid}, 32'd1);
        exp_q.push_back(32'hAB44001D);
        exp_q.push_back(32'h12345678);
        recv("t1", 100, 2);
        check("t1_pkt", {16'd0, pkt_cnt}, 32'd1);

        // Increment mode; mode change after the header must not apply
        mode = 2'd1;
        send(32'hAB740011, 1'b0);
        mode = 2'd2;
        send(32'h00000005, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        exp_q.push_back(32'hAB44001D);
        exp_q.push_back(32'h00000006);
        exp_q.push_back(32'h00000000);
        recv("t2", 100, 3);
        check("t2_pkt", {16'd0, pkt_cnt}, 32'd2);

        // Header-only packet; input stays blocked while the reply is stalled
        send(32'hAB740011, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("t3_in_blocked", {31'd0, in_ready}, 32'd0);
        end
        check("t3_hold_last", {31'd0, out_last}, 32'd1);
        exp_q.push_back(32'hAB44001D);
        recv("t3", 100, 1);
        check("t3_pkt", {16'd0, pkt_cnt}, 32'd3);

        // Full-depth 16-flit payload, loopback
        mode = 2'd0;
        send(32'hAB740011, 1'b0);
        exp_q.push_back(32'hAB44001D);
        for (int i = 0; i < 16; i++) begin
            send(32'hA5000000 + i * 32'h00010101, (i == 15));
            exp_q.push_back(32'hA5000000 + i * 32'h00010101);
        end
        recv("t4", 100, 17);
        check("t4_pkt", {16'd0, pkt_cnt}, 32'd4);

        // 17-flit payload is dropped with no output
        send(32'hAB740011, 1'b0);
        for (int i = 0; i < 17; i++) send(32'h00000100 + i, (i == 16));
        repeat (4) begin
            @(negedge clk);
            check("t5_no_out", {31'd0, out_valid}, 32'd0);
        end
        check("t5_drop", {16'd0, drop_cnt}, 32'd1);
        check("t5_pkt", {16'd0, pkt_cnt}, 32'd4);
        check("t5_ready", {31'd0, in_ready}, 32'd1);

        // Next packet after the drop, invert mode
        mode = 2'd2;
        send(32'h12FC0A55, 1'b0);
        send(32'h0F0F1234, 1'b1);
        exp_q.push_back(32'h12440A7F);
        exp_q.push_back(32'hF0F0EDCB);
        recv("t5b", 100, 2);
        check("t5b_pkt", {16'd0, pkt_cnt}, 32'd5);

        // Three 4-flit packets with ~30% ready duty, mode 3 is loopback
        mode = 2'd3;
        for (int p = 0; p < 3; p++) begin
            send(32'hAB740011, 1'b0);
            exp_q.push_back(32'hAB44001D);
            for (int i = 0; i < 4; i++) begin
                send(32'hC0DE0000 + p * 32'h100 + i, (i == 3));
                exp_q.push_back(32'hC0DE0000 + p * 32'h100 + i);
            end
            recv("t6", 30, 5);
        end
        check("t6_pkt", {16'd0, pkt_cnt}, 32'd8);

        // Reset in the middle of a packet discards it
        mode = 2'd0;
        send(32'hAB740011, 1'b0);
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        @(negedge clk);
        rst_low = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t7_rst_ready", {31'd0, in_ready}, 32'd0);
        check("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t7_rst_data", out_data, 32'd0);
        check("t7_rst_pkt", {16'd0, pkt_cnt}, 32'd0);
        check("t7_rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst_low = 1'b1;
        @(negedge clk);
        check("t7_rel_ready", {31'd0, in_ready}, 32'd1);
        send(32'hAB740011, 1'b0);
        exp_q.push_back(32'hAB44001D);
        for (int i = 0; i < 4; i++) begin
            send(32'h33330000 + i, (i == 3));
            exp_q.push_back(32'h33330000 + i);
        end
        recv("t7", 100, 5);
        check("t7_pkt", {16'd0, pkt_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
